osram_drain: RTL

//  Reads the two conv output SRAMs (SRAM_O0/SRAM_O1) after a layer completes and streams their
//  16-bit words off-chip over a valid/ready interface, interleaved O0[i], O1[i], O0[i+1], ...

---
 rtl/conv_pkg.sv | 18 +
 rtl/osram_drain_fifo.sv | 56 +++++
 rtl/osram_drain.sv | 135 +++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared constants and state type for the conv output-bank drain path.
// Bank geometry is fixed here so the top and the FIFO agree on widths.
package conv_pkg;

    localparam int WORD_AMOUNT_O  = 6272;
    localparam int BIT_PER_WORD_O = 16;
    localparam int ADDR_W         = $clog2(WORD_AMOUNT_O);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORD_AMOUNT_O - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH,
        DONE
    } drain_state_t;

endpackage

// File: rtl/osram_drain_fifo.sv
// Two-entry skid FIFO for the drain return path; its head drives the output stream.
// Push and pop in the same cycle on a full FIFO is accepted and leaves the count unchanged.
module drain_fifo
    import conv_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push_i,
    input  logic [BIT_PER_WORD_O-1:0] data_i,
    input  logic                      pop_i,
    output logic [BIT_PER_WORD_O-1:0] data_o,
    output logic                      full_o,
    output logic                      empty_o,
    output logic [1:0]                count_o
);

    logic [BIT_PER_WORD_O-1:0] mem_q [2];
    logic                      rd_ptr_q;
    logic                      wr_ptr_q;
    logic [1:0]                count_q;
    logic                      do_push;
    logic                      do_pop;

    assign full_o  = (count_q == 2'd2);
    assign empty_o = (count_q == 2'd0);
    assign count_o = count_q;
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    // An empty FIFO presents zero so the stream output is clean between runs.
    assign data_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/osram_drain.sv
// Drains conv output banks O0/O1 as an interleaved valid/ready word stream.
// Optional CHECKSUM_EN macro adds a running 32-bit sum of accepted words.
module osram_drain
    import conv_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic [ADDR_W-1:0]         addr_O0,
    output logic [ADDR_W-1:0]         addr_O1,
    output logic                      we_O0,
    output logic                      we_O1,
    input  logic [BIT_PER_WORD_O-1:0] dout_O0,
    input  logic [BIT_PER_WORD_O-1:0] dout_O1,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [BIT_PER_WORD_O-1:0] out_data,
    output logic [31:0]               checksum
);

    drain_state_t              state_q;
    logic                      busy_q;
    logic                      done_q;
    logic                      sel_q;
    logic                      rsel_q;
    logic                      inflight_q;
    logic [ADDR_W-1:0]         addr_q;

    logic                      pop;
    logic                      issue;
    logic                      last_issue;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [1:0]                fifo_count;
    logic [2:0]                occ_next;
    logic [BIT_PER_WORD_O-1:0] ret_word;

    assign pop       = out_valid && out_ready;
    assign out_valid = !fifo_empty;

    // Occupancy next cycle counts this cycle's pop, which keeps 1 word/cycle with ready high.
    assign occ_next   = {1'b0, fifo_count} - {2'b00, pop} + {2'b00, inflight_q};
    assign issue      = (state_q == IDLE && start) ||
                        (state_q == RUN && occ_next < 3'd2 && !(fifo_full && !pop));
    assign last_issue = issue && sel_q && (addr_q == LAST_ADDR);
    assign ret_word   = rsel_q ? dout_O1 : dout_O0;

    drain_fifo u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (inflight_q),
        .data_i  (ret_word),
        .pop_i   (pop),
        .data_o  (out_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            sel_q      <= 1'b0;
            rsel_q     <= 1'b0;
            inflight_q <= 1'b0;
            addr_q     <= '0;
        end else begin
            inflight_q <= issue;
            done_q     <= 1'b0;
            if (issue) begin
                rsel_q <= sel_q;
                sel_q  <= ~sel_q;
                if (sel_q && !last_issue) begin
                    addr_q <= addr_q + ADDR_W'(1);
                end
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                    end
                end
                RUN: begin
                    if (last_issue) begin
                        state_q <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (fifo_empty && !inflight_q) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    addr_q  <= '0;
                    sel_q   <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign addr_O0 = addr_q;
    assign addr_O1 = addr_q;
    assign we_O0   = 1'b0;
    assign we_O1   = 1'b0;

`ifdef CHECKSUM_EN
    logic [31:0] checksum_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            checksum_q <= 32'd0;
        end else if (state_q == IDLE && start) begin
            checksum_q <= 32'd0;
        end else if (pop) begin
            checksum_q <= checksum_q + {{(32-BIT_PER_WORD_O){1'b0}}, out_data};
        end
    end

    assign checksum = checksum_q;
`else
    assign checksum = 32'd0;
`endif

endmodule
